// File: rtl/conv2d_ctrl_pkg.sv
// Shared types and constants for the Sobel frame controller.
// Holds the sequencer state encoding, the interior-window margin and a
// helper that sizes coordinate counters from an image dimension.
package conv2d_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_e;

    // A 3x3 window is fully inside the image once two rows and two columns
    // have been seen before the current pixel.
    localparam int WIN_MARGIN = 2;

    // Bits needed to hold a coordinate in [0, n-1]; never narrower than 1.
    function automatic int coord_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv2d_coord_cnt.sv
// Row/column position of accepted pixels within a frame.
// Column advances on every beat and wraps at the image width; the row
// advances on each column wrap and wraps after the final row.
module conv2d_coord_cnt
    import conv2d_ctrl_pkg::*;
#(
    parameter int IMG_W_P = 16,
    parameter int IMG_H_P = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clr_i,
    input  logic                          beat_i,
    output logic [coord_w(IMG_H_P)-1:0]   row_o,
    output logic [coord_w(IMG_W_P)-1:0]   col_o,
    output logic                          col_wrap_o,
    output logic                          row_last_o
);

    localparam int ROW_W = coord_w(IMG_H_P);
    localparam int COL_W = coord_w(IMG_W_P);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H_P - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W_P - 1);

    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_q;

    assign row_o      = row_q;
    assign col_o      = col_q;
    assign col_wrap_o = (col_q == COL_MAX);
    assign row_last_o = (row_q == ROW_MAX);

    // Position update: clear wins over beat, column carry feeds the row.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            row_q <= '0;
            col_q <= '0;
        end else if (clr_i) begin
            row_q <= '0;
            col_q <= '0;
        end else if (beat_i) begin
            if (col_wrap_o) begin
                col_q <= '0;
                row_q <= row_last_o ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv2d_frame_ctrl.sv
// Frame sequencer for the 3x3 Sobel engine.
// Arms one frame per start, pulses the engine's line-buffer reset for one
// cycle, gates the pixel handshake while running, and marks which engine
// outputs are full interior windows together with their centre coordinates.
// Optional macro CONV2D_FRAME_CTRL_STATS_EN enables the backpressure stall
// counter on stall_cnt_o; without it the port reads zero.
module conv2d_frame_ctrl
    import conv2d_ctrl_pkg::*;
#(
    parameter int WIDTH_P   = 8,
    parameter int IMG_W_P   = 16,
    parameter int IMG_H_P   = 16,
    parameter int STALL_W_P = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic                          abort_i,
    output logic                          busy_o,
    output logic                          done_o,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    input  logic [WIDTH_P-1:0]            s_data_i,
    output logic                          c_valid_o,
    input  logic                          c_ready_i,
    output logic [WIDTH_P-1:0]            c_data_o,
    output logic                          c_rstn_o,
    output logic                          win_valid_o,
    output logic [coord_w(IMG_H_P)-1:0]   win_row_o,
    output logic [coord_w(IMG_W_P)-1:0]   win_col_o,
    output logic                          win_last_o,
    output logic [STALL_W_P-1:0]          stall_cnt_o
);

    localparam int ROW_W = coord_w(IMG_H_P);
    localparam int COL_W = coord_w(IMG_W_P);
    localparam logic [ROW_W-1:0] ROW_MARGIN = ROW_W'(WIN_MARGIN);
    localparam logic [COL_W-1:0] COL_MARGIN = COL_W'(WIN_MARGIN);

    ctrl_state_e      state_q, state_d;
    logic             rstn_fsm;
    logic             beat;
    logic             win_take;
    logic             cnt_clr;
    logic             col_wrap;
    logic             row_last;
    logic             frame_last;
    logic             interior;
    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_q;

    logic             win_vld_p1;
    logic             win_last_p1;
    logic [ROW_W-1:0] win_row_p1;
    logic [COL_W-1:0] win_col_p1;

    assign c_data_o = s_data_i;
    assign beat     = s_valid_i & s_ready_o;
    // A beat in the abort cycle still reaches the engine but is not reported.
    assign win_take = beat & ~abort_i;
    // The engine stays in reset for as long as the controller does.
    assign c_rstn_o = rstn_fsm & ~rst_i;

    // Counters only move while running; abort returns them to the origin.
    assign cnt_clr    = (state_q != ST_RUN) | abort_i;
    assign frame_last = col_wrap & row_last;
    // Compare before decrementing so the centre coordinate never underflows.
    assign interior   = (row_q >= ROW_MARGIN) && (col_q >= COL_MARGIN);

    conv2d_coord_cnt #(
        .IMG_W_P (IMG_W_P),
        .IMG_H_P (IMG_H_P)
    ) u_coord (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (cnt_clr),
        .beat_i     (beat),
        .row_o      (row_q),
        .col_o      (col_q),
        .col_wrap_o (col_wrap),
        .row_last_o (row_last)
    );

    // Sequencer state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state and handshake gating; abort outranks start and frame end.
    always_comb begin
        state_d   = state_q;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        s_ready_o = 1'b0;
        c_valid_o = 1'b0;
        rstn_fsm  = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                busy_o   = 1'b1;
                rstn_fsm = 1'b0;
                state_d  = abort_i ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                busy_o    = 1'b1;
                s_ready_o = c_ready_i;
                c_valid_o = s_valid_i;
                if (abort_i)                                   state_d = ST_IDLE;
                else if (s_valid_i && c_ready_i && frame_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage p1: window flags line up with the engine output one cycle after the beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            win_vld_p1  <= 1'b0;
            win_last_p1 <= 1'b0;
            win_row_p1  <= '0;
            win_col_p1  <= '0;
        end else begin
            win_vld_p1  <= win_take & interior;
            win_last_p1 <= win_take & frame_last;
            if (win_take && interior) begin
                win_row_p1 <= row_q - 1'b1;
                win_col_p1 <= col_q - 1'b1;
            end
        end
    end

    assign win_valid_o = win_vld_p1;
    assign win_last_o  = win_last_p1;
    assign win_row_o   = win_row_p1;
    assign win_col_o   = win_col_p1;

`ifdef CONV2D_FRAME_CTRL_STATS_EN
    logic [STALL_W_P-1:0] stall_q;

    function automatic logic [STALL_W_P-1:0] sat_inc(input logic [STALL_W_P-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Stall statistics: restart when a frame is armed, count blocked RUN cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                            stall_q <= '0;
        else if (state_q == ST_IDLE && state_d == ST_CLEAR)   stall_q <= '0;
        else if (state_q == ST_RUN && s_valid_i && !c_ready_i) stall_q <= sat_inc(stall_q);
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_conv2d_frame_ctrl.sv
// Bench for conv2d_frame_ctrl: a 4x4 and a 16x16 instance driven with
// randomized handshakes; expected windows come from the pixel index of each
// accepted beat and are checked by an independent monitor.
module tb_conv2d_frame_ctrl;

    localparam int DW = 8;

    typedef struct {
        int row;
        int col;
        bit last;
    } win_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start [2];
    logic          abort [2];
    logic          s_valid [2];
    logic          c_ready [2];
    logic [DW-1:0] s_data [2];
    logic [DW-1:0] c_data [2];
    logic          busy [2];
    logic          done [2];
    logic          s_ready [2];
    logic          c_valid [2];
    logic          c_rstn [2];
    logic          win_valid [2];
    logic          win_last [2];
    logic [3:0]    win_row [2];
    logic [3:0]    win_col [2];
    logic [15:0]   stall [2];
    logic [1:0]    row4, col4;

    assign win_row[0] = {2'b00, row4};
    assign win_col[0] = {2'b00, col4};

    int   n_chk = 0;
    int   n_pass = 0;
    int   win_cnt [2];
    int   done_cnt [2];
    win_t q0[$];
    win_t q1[$];

    conv2d_frame_ctrl #(.WIDTH_P(DW), .IMG_W_P(4), .IMG_H_P(4), .STALL_W_P(16)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start[0]), .abort_i(abort[0]),
        .busy_o(busy[0]), .done_o(done[0]),
        .s_valid_i(s_valid[0]), .s_ready_o(s_ready[0]), .s_data_i(s_data[0]),
        .c_valid_o(c_valid[0]), .c_ready_i(c_ready[0]), .c_data_o(c_data[0]),
        .c_rstn_o(c_rstn[0]), .win_valid_o(win_valid[0]), .win_row_o(row4),
        .win_col_o(col4), .win_last_o(win_last[0]), .stall_cnt_o(stall[0])
    );

    conv2d_frame_ctrl #(.WIDTH_P(DW), .IMG_W_P(16), .IMG_H_P(16), .STALL_W_P(16)) u_dut16 (
        .clk_i(clk), .rst_i(rst), .start_i(start[1]), .abort_i(abort[1]),
        .busy_o(busy[1]), .done_o(done[1]),
        .s_valid_i(s_valid[1]), .s_ready_o(s_ready[1]), .s_data_i(s_data[1]),
        .c_valid_o(c_valid[1]), .c_ready_i(c_ready[1]), .c_data_o(c_data[1]),
        .c_rstn_o(c_rstn[1]), .win_valid_o(win_valid[1]), .win_row_o(win_row[1]),
        .win_col_o(win_col[1]), .win_last_o(win_last[1]), .stall_cnt_o(stall[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: event outside expectation (t=%0t)", name, $time);
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    // Reference: the k-th accepted pixel of a frame sits at (k/w, k%w).
    task automatic model_push(input int d, input int k, input int w);
        win_t e;
        int r = k / w;
        int c = k % w;
        if (r >= 2 && c >= 2) begin
            e.row  = r - 1;
            e.col  = c - 1;
            e.last = (k == w * w - 1);
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    // Monitor: every flagged window must match the oldest predicted one.
    initial begin
        win_t e;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (done[d]) done_cnt[d]++;
                if (done[d] || win_last[d]) chk("done_with_last", done[d], win_last[d]);
                if (win_valid[d]) begin
                    win_cnt[d]++;
                    if (qsize(d) == 0) fail_now("win_unexpected");
                    else begin
                        if (d == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        chk("win_row", win_row[d], e.row);
                        chk("win_col", win_col[d], e.col);
                        chk("win_last", win_last[d], e.last);
                    end
                end else if (win_last[d]) begin
                    chk("last_without_valid", win_last[d], 0);
                end
            end
        end
    end

    // mode 0: full frame, 1: abort at beat stop_at, 2: async reset at beat stop_at
    task automatic do_frame(input int d, input int vpct, input int rpct,
                            input int mode, input int stop_at, input bit hold);
        int w = (d == 0) ? 4 : 16;
        int n = w * w;
        int k = 0;
        int stalls = 0;
        int cyc = 0;
        int wc0 = win_cnt[d];
        int dc0 = done_cnt[d];
        int exp_stall;
        bit ab;
        @(negedge clk);
        s_valid[d] = 1'b0;
        c_ready[d] = 1'b1;
        start[d]   = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start[d] = 1'b0;
        chk("clear_busy", busy[d], 1);
        chk("clear_rstn", c_rstn[d], 0);
        chk("clear_s_ready", s_ready[d], 0);
        @(posedge clk);
        while (k < n) begin
            if (cyc > 4 * n + 100) begin
                fail_now("frame_timeout");
                break;
            end
            cyc++;
            @(negedge clk);
            ab = 1'b0;
            if (mode == 2 && k == stop_at) begin
                s_valid[d] = 1'b0;
                @(posedge clk);
                #3 rst = 1'b1;
                #1;
                chk("arst_busy", busy[d], 0);
                chk("arst_done", done[d], 0);
                chk("arst_win_valid", win_valid[d], 0);
                chk("arst_win_row", win_row[d], 0);
                chk("arst_win_col", win_col[d], 0);
                chk("arst_rstn", c_rstn[d], 0);
                chk("arst_s_ready", s_ready[d], 0);
                @(negedge clk);
                rst = 1'b0;
                start[d] = 1'b0;
                if (d == 0) q0.delete();
                else        q1.delete();
                return;
            end
            s_valid[d] = ($urandom_range(0, 99) < vpct);
            c_ready[d] = ($urandom_range(0, 99) < rpct);
            s_data[d]  = DW'($urandom);
            if (mode == 1 && k == stop_at) begin
                s_valid[d] = 1'b1;
                c_ready[d] = 1'b1;
                abort[d]   = 1'b1;
                ab         = 1'b1;
            end
            #1;
            chk("run_rstn", c_rstn[d], 1);
            chk("c_valid", c_valid[d], s_valid[d]);
            chk("s_ready", s_ready[d], c_ready[d]);
            chk("c_data", c_data[d], s_data[d]);
            if (s_valid[d] && !c_ready[d]) stalls++;
            if (s_valid[d] && c_ready[d]) begin
                if (!ab) model_push(d, k, w);
                k++;
                if (k == n) start[d] = 1'b0;
            end
            @(posedge clk);
            if (ab) begin
                @(negedge clk);
                abort[d]   = 1'b0;
                s_valid[d] = 1'b0;
                chk("abort_busy", busy[d], 0);
                chk("abort_done", done[d], 0);
                repeat (2) @(negedge clk);
                chk("abort_no_done", done_cnt[d] - dc0, 0);
                chk("abort_queue_empty", qsize(d), 0);
                return;
            end
        end
        @(negedge clk);
        s_valid[d] = 1'b0;
        chk("done_pulse", done[d], 1);
        chk("done_busy", busy[d], 0);
`ifdef CONV2D_FRAME_CTRL_STATS_EN
        exp_stall = stalls;
`else
        exp_stall = 0;
`endif
        chk("stall_cnt", int'(stall[d]), exp_stall);
        @(negedge clk);
        chk("done_one_cycle", done[d], 0);
        chk("idle_busy", busy[d], 0);
        chk("frame_windows", win_cnt[d] - wc0, (w - 2) * (w - 2));
        chk("frame_done_count", done_cnt[d] - dc0, 1);
        chk("frame_queue_empty", qsize(d), 0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; abort[d] = 1'b0; s_valid[d] = 1'b0;
            c_ready[d] = 1'b0; s_data[d] = '0; win_cnt[d] = 0; done_cnt[d] = 0;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", busy[d], 0);
            chk("rst_done", done[d], 0);
            chk("rst_win_valid", win_valid[d], 0);
            chk("rst_win_last", win_last[d], 0);
            chk("rst_win_row", win_row[d], 0);
            chk("rst_win_col", win_col[d], 0);
            chk("rst_rstn", c_rstn[d], 0);
            chk("rst_stall", int'(stall[d]), 0);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("idle_rstn", c_rstn[d], 1);
            chk("idle_s_ready", s_ready[d], 0);
        end

        do_frame(0, 100, 100, 0, 0, 1'b0);
        do_frame(1, 80, 60, 0, 0, 1'b0);

        // Valid offered in IDLE without start: nothing is accepted.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_valid[1] = 1'b1;
            c_ready[1] = 1'b1;
            #1;
            chk("idle_gate_ready", s_ready[1], 0);
            chk("idle_gate_valid", c_valid[1], 0);
            chk("idle_gate_busy", busy[1], 0);
        end
        @(negedge clk);
        s_valid[1] = 1'b0;

        do_frame(0, 100, 100, 1, 10, 1'b0);
        do_frame(0, 90, 80, 0, 0, 1'b0);

        // start and abort together in IDLE: stays idle.
        @(negedge clk);
        start[0] = 1'b1;
        abort[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("start_abort_busy", busy[0], 0);
        chk("start_abort_rstn", c_rstn[0], 1);
        @(negedge clk);
        start[0] = 1'b0;
        abort[0] = 1'b0;

        do_frame(1, 90, 70, 0, 0, 1'b1);
        repeat (3) @(negedge clk);
        chk("held_start_no_rerun", busy[1], 0);

        do_frame(1, 100, 100, 2, 40, 1'b0);
        do_frame(1, 85, 75, 0, 0, 1'b0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
